flag_branch_ctrl: RTL and testbench
===================================

Name: flag_branch_ctrl

Overview:
- Consumer side of the ALU result interface.
- Latches the ALU status outputs (Zero, Par, SCo and the 2-bit compare result) into a flag register.
- Evaluates conditional branches against the latched flags and owns the program counter: sequential increment, LUT-based absolute branch targets, stall, halt and start/done handshake.
- Sits between the ALU/decoder and instruction memory.

Parameters:
- PC_W, 10, program counter width.
- LUT_W, 5, branch-target LUT index width (2^LUT_W entries of PC_W bits).

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to (re)start the program at PC 0.
- Stall  in  1  hold PC, flags and FSM state this cycle.
- Halt  in  1  current instruction is the terminating instruction.
- FlagWe  in  1  latch ALU status this cycle.
- Zero  in  1  ALU zero flag.
- Par  in  1  ALU parity flag.
- SCo  in  1  ALU shift/carry-out flag.
- CmpIn  in  2  ALU result bits [1:0]; bit0 = not-equal, bit1 = greater.
- BrType  in  3  branch kind (see Behaviour).
- BrIdx  in  LUT_W  LUT index of branch target.
- LutWe  in  1  LUT write enable.
- LutWAddr  in  LUT_W  LUT write index.
- LutWData  in  PC_W  LUT write data.
- Pc  out  PC_W  current instruction address.
- FlagsQ  out  5  registered flags {CmpIn[1],CmpIn[0],SCo,Par,Zero}.
- Taken  out  1  high for the one cycle in which Pc holds a branch target.
- Done  out  1  program finished.

Behaviour:
- Reset (Reset_n=0, async): state IDLE, Pc=0, FlagsQ=0, Taken=0, Done=0, all LUT entries 0. Reset mid-RUN aborts immediately; no further PC update until the next Start.
- FSM states are IDLE, RUN and DONE.
  - IDLE: Pc holds 0. Start=1 moves to RUN with Pc=0.
  - RUN: see the per-cycle rules below.
  - DONE: Done=1, Pc frozen. Start=1 moves to RUN with Pc=0 and Done=0. All other inputs are ignored, except LUT writes.
- Start has highest priority in every state, including over Stall and Halt. In RUN it restarts with Pc=0, Taken=0 and flags retained.
- RUN, Stall=1: Pc, FlagsQ and state hold. Taken=0. FlagWe is ignored.
- RUN, Stall=0:
  - Halt=1: move to DONE, Pc holds, no branch evaluated.
  - Otherwise, branch taken: Pc <= LUT[BrIdx] and Taken<=1.
  - Otherwise: Pc <= Pc+1, wrapping from 2^PC_W-1 to 0, and Taken<=0.
  - FlagWe=1: FlagsQ <= {CmpIn,SCo,Par,Zero}.
- BrType encoding. All conditions test FlagsQ (the registered value), never the current-cycle inputs. With FlagWe and a branch in the same cycle, the branch sees the old flags.
  - 000: none.
  - 001: always.
  - 010: Zero.
  - 011: !Zero.
  - 100: greater (cmp1 & cmp0).
  - 101: less (!cmp1 & cmp0).
  - 110: SCo.
  - 111: Par.
- Branch latency: target visible on Pc one cycle after the branch cycle. No delay slot.
- LUT writes are accepted in any state, including during Stall and Halt. Read is combinational from stored contents. A write and a read of the same index in the same cycle returns the old value; the new value is visible next cycle.
- Outside RUN, FlagWe, BrType, BrIdx and Halt have no effect.

Decomposition:
- Shared package flag_branch_pkg holds:
  - br_type_t enum (8 codes above);
  - state_t enum {IDLE,RUN,DONE};
  - flag bit index constants (FLG_Z=0, FLG_P=1, FLG_C=2, FLG_NE=3, FLG_GT=4).
- One sub-module, branch_lut: 2^LUT_W x PC_W register file with one synchronous write port, one async read port and async active-low clear.
- Condition evaluation and FSM stay in flag_branch_ctrl.

Test Plan:
- Reset, then Start pulse, 5 idle cycles with BrType=000 -> Pc sequence 0,1,2,3,4,5; Taken=0; Done=0.
- LUT[3]=0x2A0. At Pc=4: FlagWe with Zero=1 and BrType=010 in the same cycle -> not taken (old Z=0), Pc=5. Next cycle BrType=010 -> Pc=0x2A0, Taken=1 for exactly one cycle.
- FlagsQ with CmpIn=2'b01, BrType=101 -> taken. Same with CmpIn=2'b11 -> not taken. BrType=100 with 2'b11 -> taken.
- Stall=1 for 3 cycles with FlagWe=1 and BrType=001 -> Pc, FlagsQ and Taken unchanged. Release -> branch taken on the next cycle.
- Halt at Pc=7 -> Done=1 next cycle, Pc stays 7 for 10 cycles. Start -> Pc=0, Done=0. Pc at 0x3FF with no branch -> wraps to 0.
- Reset_n low mid-RUN (Pc=0x15, FlagsQ=5'h1F) -> Pc=0, FlagsQ=0, LUT cleared, Done=0 asynchronously. Pc holds 0 until the next Start.

Source files
------------

// File: rtl/flag_branch_ctrl_pkg.sv
// flag_branch_pkg: shared types and constants for the flag/branch controller.
//   br_type_t : branch condition codes carried on BrType
//   state_t   : controller FSM states
//   FLG_*     : bit positions inside the registered flag vector FlagsQ
package flag_branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE   = 3'b000,
    BR_ALWAYS = 3'b001,
    BR_Z      = 3'b010,
    BR_NZ     = 3'b011,
    BR_GT     = 3'b100,
    BR_LT     = 3'b101,
    BR_C      = 3'b110,
    BR_P      = 3'b111
  } br_type_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int FLG_Z  = 0;
  localparam int FLG_P  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_NE = 3;
  localparam int FLG_GT = 4;

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// flag_branch_ctrl_if: ALU/decoder-facing bundle of the flag/branch controller.
//   Control : Start, Stall, Halt
//   Flags   : FlagWe, Zero, Par, SCo, CmpIn[1:0] (bit0 not-equal, bit1 greater)
//   Branch  : BrType[2:0], BrIdx
//   LUT     : LutWe, LutWAddr, LutWData
//   Results : Pc, FlagsQ {CmpIn[1],CmpIn[0],SCo,Par,Zero}, Taken, Done
// master = decoder/ALU side, slave = controller side.
interface flag_branch_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
);
  logic             Start;
  logic             Stall;
  logic             Halt;
  logic             FlagWe;
  logic             Zero;
  logic             Par;
  logic             SCo;
  logic [1:0]       CmpIn;
  logic [2:0]       BrType;
  logic [LUT_W-1:0] BrIdx;
  logic             LutWe;
  logic [LUT_W-1:0] LutWAddr;
  logic [PC_W-1:0]  LutWData;
  logic [PC_W-1:0]  Pc;
  logic [4:0]       FlagsQ;
  logic             Taken;
  logic             Done;

  modport master (
    output Start, Stall, Halt, FlagWe, Zero, Par, SCo, CmpIn,
           BrType, BrIdx, LutWe, LutWAddr, LutWData,
    input  Pc, FlagsQ, Taken, Done
  );

  modport slave (
    input  Start, Stall, Halt, FlagWe, Zero, Par, SCo, CmpIn,
           BrType, BrIdx, LutWe, LutWAddr, LutWData,
    output Pc, FlagsQ, Taken, Done
  );
endinterface

// File: rtl/flag_branch_ctrl_branch_lut.sv
// branch_lut: 2^LUT_W x PC_W branch-target register file.
//   clk, rst_n : clock, async active-low clear of every entry
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port (returns pre-write contents
//                      when the same entry is written in this cycle)
module branch_lut #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [LUT_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [LUT_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);
  localparam int unsigned DEPTH = 1 << LUT_W;

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/flag_branch_ctrl.sv
// flag_branch_ctrl: latches ALU status flags and drives the program counter.
//   Clk, Reset_n : clock, async active-low reset
//   bus (slave)  : Start/Stall/Halt control, ALU flags with FlagWe, branch
//                  type/LUT index, LUT write port; outputs Pc, FlagsQ,
//                  Taken (Pc holds a branch target) and Done.
// Branch conditions test the registered flags, so a flag write and a branch
// in the same cycle see the previous flags.
module flag_branch_ctrl
  import flag_branch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input logic               Clk,
  input logic               Reset_n,
  flag_branch_ctrl_if.slave bus
);
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target;
  logic [4:0]      flags_q, flags_d;
  logic            taken_q, taken_d;
  logic            br_cond;
  br_type_t        br_type;

  branch_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_lut (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (bus.LutWe),
    .waddr (bus.LutWAddr),
    .wdata (bus.LutWData),
    .raddr (bus.BrIdx),
    .rdata (target)
  );

  assign br_type = br_type_t'(bus.BrType);

  always_comb begin
    br_cond = 1'b0;
    case (br_type)
      BR_NONE:   br_cond = 1'b0;
      BR_ALWAYS: br_cond = 1'b1;
      BR_Z:      br_cond = flags_q[FLG_Z];
      BR_NZ:     br_cond = !flags_q[FLG_Z];
      BR_GT:     br_cond = flags_q[FLG_GT] && flags_q[FLG_NE];
      BR_LT:     br_cond = !flags_q[FLG_GT] && flags_q[FLG_NE];
      BR_C:      br_cond = flags_q[FLG_C];
      BR_P:      br_cond = flags_q[FLG_P];
      default:   br_cond = 1'b0;
    endcase
  end

  // Start overrides everything; otherwise only an unstalled RUN cycle moves.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    taken_d = 1'b0;
    if (bus.Start) begin
      state_d = RUN;
      pc_d    = '0;
    end else if (state_q == RUN && !bus.Stall) begin
      if (bus.FlagWe) flags_d = {bus.CmpIn, bus.SCo, bus.Par, bus.Zero};
      if (bus.Halt) begin
        state_d = DONE;
      end else if (br_cond) begin
        pc_d    = target;
        taken_d = 1'b1;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      flags_q <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      taken_q <= taken_d;
    end
  end

  assign bus.Pc     = pc_q;
  assign bus.FlagsQ = flags_q;
  assign bus.Taken  = taken_q;
  assign bus.Done   = (state_q == DONE);
endmodule

// File: tb/tb_flag_branch_ctrl.sv
module tb_flag_branch_ctrl;
  localparam int PC_W  = 10;
  localparam int LUT_W = 5;
  localparam int PC_MOD = 1 << PC_W;

  logic Clk;
  logic Reset_n;

  flag_branch_ctrl_if #(.PC_W(PC_W), .LUT_W(LUT_W)) bus ();

  flag_branch_ctrl #(.PC_W(PC_W), .LUT_W(LUT_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: mode 0 = idle, 1 = running, 2 = finished
  int       m_mode;
  int       m_pc;
  bit [4:0] m_flags;
  bit       m_taken;
  int       m_lut [1 << LUT_W];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit cond(input int bt, input bit [4:0] f);
    // f = {greater, not_equal, sco, par, zero}
    case (bt)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return f[0];
      3:       return !f[0];
      4:       return f[4] && f[3];
      5:       return !f[4] && f[3];
      6:       return f[2];
      default: return f[1];
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 0;
    m_flags = '0;
    m_taken = 1'b0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic clear_in();
    bus.Start    = 1'b0;
    bus.Stall    = 1'b0;
    bus.Halt     = 1'b0;
    bus.FlagWe   = 1'b0;
    bus.Zero     = 1'b0;
    bus.Par      = 1'b0;
    bus.SCo      = 1'b0;
    bus.CmpIn    = 2'b00;
    bus.BrType   = 3'b000;
    bus.BrIdx    = '0;
    bus.LutWe    = 1'b0;
    bus.LutWAddr = '0;
    bus.LutWData = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pc"},    int'(bus.Pc),     m_pc);
    check({tag, "_flags"}, int'(bus.FlagsQ), int'(m_flags));
    check({tag, "_taken"}, int'(bus.Taken),  int'(m_taken));
    check({tag, "_done"},  int'(bus.Done),   (m_mode == 2) ? 1 : 0);
  endtask

  // One clock: inputs are already driven; model advances at the edge,
  // outputs are compared on the following falling edge.
  task automatic step(input string tag);
    int       tgt;
    bit [4:0] old;
    @(posedge Clk);
    tgt = m_lut[int'(bus.BrIdx)];
    old = m_flags;
    if (bus.Start) begin
      m_mode  = 1;
      m_pc    = 0;
      m_taken = 1'b0;
    end else if (m_mode == 1 && !bus.Stall) begin
      if (bus.FlagWe) m_flags = {bus.CmpIn, bus.SCo, bus.Par, bus.Zero};
      if (bus.Halt) begin
        m_mode  = 2;
        m_taken = 1'b0;
      end else if (cond(int'(bus.BrType), old)) begin
        m_pc    = tgt;
        m_taken = 1'b1;
      end else begin
        m_pc    = (m_pc + 1) % PC_MOD;
        m_taken = 1'b0;
      end
    end else begin
      m_taken = 1'b0;
    end
    if (bus.LutWe) m_lut[int'(bus.LutWAddr)] = int'(bus.LutWData);
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic lut_write(input int idx, input int val);
    clear_in();
    bus.LutWe    = 1'b1;
    bus.LutWAddr = LUT_W'(idx);
    bus.LutWData = PC_W'(val);
  endtask

  task automatic start_prog();
    clear_in();
    bus.Start = 1'b1;
    step("start");
    clear_in();
  endtask

  initial begin
    clear_in();
    model_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_all("reset");
    Reset_n = 1'b1;
    step("idle_hold");

    // sequential run 0..5 with LUT[3] loaded while starting
    clear_in();
    bus.Start    = 1'b1;
    bus.LutWe    = 1'b1;
    bus.LutWAddr = 5'd3;
    bus.LutWData = 10'h2A0;
    step("start_lut");
    clear_in();
    for (int i = 1; i <= 4; i++) step("seq");
    check("seq_pc4", int'(bus.Pc), 4);

    // flag write and branch in the same cycle: branch sees old Z=0
    bus.FlagWe = 1'b1;
    bus.Zero   = 1'b1;
    bus.BrType = 3'b010;
    bus.BrIdx  = 5'd3;
    step("fw_br_same");
    check("fw_br_same_pc5", int'(bus.Pc), 5);
    clear_in();
    bus.BrType = 3'b010;
    bus.BrIdx  = 5'd3;
    step("br_z");
    check("br_z_target", int'(bus.Pc), 'h2A0);
    check("br_z_taken", int'(bus.Taken), 1);
    clear_in();
    step("after_br");
    check("after_br_taken", int'(bus.Taken), 0);

    // compare-result branches
    bus.FlagWe = 1'b1;
    bus.CmpIn  = 2'b01;
    step("cmp01");
    clear_in();
    bus.BrType = 3'b101;
    bus.BrIdx  = 5'd3;
    step("lt_taken");
    check("lt_taken_pc", int'(bus.Pc), 'h2A0);
    clear_in();
    bus.FlagWe = 1'b1;
    bus.CmpIn  = 2'b11;
    step("cmp11");
    clear_in();
    bus.BrType = 3'b101;
    bus.BrIdx  = 5'd3;
    step("lt_not_taken");
    check("lt_not_taken_pc", int'(bus.Pc), 'h2A2);
    bus.BrType = 3'b100;
    step("gt_taken");
    check("gt_taken_pc", int'(bus.Pc), 'h2A0);

    // stall holds everything, branch resolves once released
    clear_in();
    step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      bus.Stall  = 1'b1;
      bus.FlagWe = 1'b1;
      bus.Zero   = 1'b1;
      bus.Par    = 1'b1;
      bus.CmpIn  = 2'b10;
      bus.BrType = 3'b001;
      bus.BrIdx  = 5'd3;
      step("stall");
      check("stall_pc", int'(bus.Pc), 'h2A1);
    end
    clear_in();
    bus.BrType = 3'b001;
    bus.BrIdx  = 5'd3;
    step("stall_release");
    check("stall_release_pc", int'(bus.Pc), 'h2A0);

    // halt at Pc=7, frozen while done, restart
    start_prog();
    for (int i = 0; i < 7; i++) step("to7");
    bus.Halt = 1'b1;
    step("halt");
    check("halt_done", int'(bus.Done), 1);
    for (int i = 0; i < 10; i++) begin
      bus.Halt   = 1'($urandom);
      bus.Stall  = 1'($urandom);
      bus.FlagWe = 1'($urandom);
      bus.Zero   = 1'($urandom);
      bus.BrType = 3'b001;
      bus.BrIdx  = 5'd3;
      step("done_hold");
    end
    check("done_pc7", int'(bus.Pc), 7);
    start_prog();
    check("restart_done", int'(bus.Done), 0);

    // wrap from 0x3FF to 0
    lut_write(5, 'h3FE);
    step("lut5");
    clear_in();
    bus.BrType = 3'b001;
    bus.BrIdx  = 5'd5;
    step("to_3fe");
    clear_in();
    step("to_3ff");
    step("wrap");
    check("wrap_pc0", int'(bus.Pc), 0);

    // randomized traffic
    start_prog();
    for (int i = 0; i < 500; i++) begin
      bus.Start    = ($urandom_range(0, 31) == 0);
      bus.Stall    = ($urandom_range(0, 3) == 0);
      bus.Halt     = ($urandom_range(0, 15) == 0);
      bus.FlagWe   = 1'($urandom);
      bus.Zero     = 1'($urandom);
      bus.Par      = 1'($urandom);
      bus.SCo      = 1'($urandom);
      bus.CmpIn    = 2'($urandom);
      bus.BrType   = 3'($urandom);
      bus.BrIdx    = LUT_W'($urandom);
      bus.LutWe    = ($urandom_range(0, 3) == 0);
      bus.LutWAddr = LUT_W'($urandom);
      bus.LutWData = PC_W'($urandom);
      step("rand");
    end

    // async reset in the middle of a run
    start_prog();
    lut_write(7, 'h15);
    step("lut7");
    clear_in();
    bus.FlagWe = 1'b1;
    bus.Zero   = 1'b1;
    bus.Par    = 1'b1;
    bus.SCo    = 1'b1;
    bus.CmpIn  = 2'b11;
    bus.BrType = 3'b001;
    bus.BrIdx  = 5'd7;
    step("to_15");
    check("mid_pc15", int'(bus.Pc), 'h15);
    check("mid_flags", int'(bus.FlagsQ), 'h1F);
    clear_in();
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst_idle");
    check("post_rst_pc", int'(bus.Pc), 0);
    start_prog();
    bus.BrType = 3'b001;
    bus.BrIdx  = 5'd3;
    step("lut_cleared");
    check("lut_cleared_pc", int'(bus.Pc), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
